program_loader: RTL
===================

PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 Parameter BASE_ADDR, default 8'h00: first instruction-memory address written by each frame.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 start  input  1  one-cycle request to begin receiving a frame.
REQ-005 in_data  input  8  incoming frame byte.
REQ-006 in_valid  input  1  in_data valid this cycle.
REQ-007 in_ready  output  1  loader accepts a byte this cycle; a byte transfers when in_valid and in_ready are both high.
REQ-008 mem_we  output  1  write strobe to the writable instruction memory.
REQ-009 mem_addr  output  8  write address.
REQ-010 mem_wdata  output  8  instruction byte to write.
REQ-011 busy  output  1  high in LEN, DATA and CSUM.
REQ-012 done  output  1  frame received with a good checksum; held high.
REQ-013 error  output  1  frame rejected; held high.
REQ-014 count  output  9  payload bytes written in the current or last frame.

Function
REQ-015 Frame format: LEN byte N (1..255), then N payload bytes, then one checksum byte C; the frame is good when (sum of payload + C) mod 256 == 0.
REQ-016 States: IDLE, LEN, DATA, CSUM, DONE, ERR.
REQ-017 IDLE/DONE/ERR + start -> LEN; the transition clears done, error, count and the running sum and loads the write pointer with BASE_ADDR.
REQ-018 start in LEN, DATA or CSUM is ignored.
REQ-019 in_ready is high only in LEN, DATA and CSUM; it is a function of state only and does not depend on in_valid.
REQ-020 LEN, byte accepted: N==0 -> ERR; else store N as the remaining count -> DATA.
REQ-021 DATA, byte accepted: add it to the 8-bit running sum (mod 256) and decrement remaining; on the Nth byte -> CSUM.
REQ-022 Each accepted payload byte produces exactly one mem_we pulse in the following cycle, with mem_addr = pointer and mem_wdata = that byte; the pointer then increments mod 256 (0xFF wraps to 0x00); count increments in the same cycle as the pulse.
REQ-023 mem_we is low in every other cycle; mem_addr and mem_wdata hold their last values while mem_we is low.
REQ-024 CSUM, byte accepted: (sum + C) mod 256 == 0 -> DONE with done=1; else -> ERR with error=1.
REQ-025 In ERR, bytes already written stay in memory; there is no rollback.
REQ-026 A cycle without a transfer (in_valid low) changes no state, sum or count; there is no timeout.
REQ-027 done and error are never high together, and both stay stable until the next accepted start or reset.

Reset
REQ-028 rst_n low immediately forces IDLE; in_ready, mem_we, busy, done and error go to 0, mem_addr to BASE_ADDR, mem_wdata to 0x00, count to 0; sum and remaining are cleared.
REQ-029 Reset mid-frame abandons the frame with no further mem_we; memory already written is not restored.
REQ-030 After rst_n deasserts, the loader stays in IDLE until start.

Verification
REQ-031 BASE_ADDR=0, start, then 03,B0,B5,BA,E1 back-to-back -> writes B0@00, B5@01, BA@02, each one cycle after its transfer; then done=1, error=0, count=3.
REQ-032 Same frame with checksum E2 -> three writes occur, then error=1, done=0, count=3.
REQ-033 BASE_ADDR=FE, LEN=04, payload 11,22,33,44, checksum 56 -> writes at FE, FF, 00, 01; done=1.
REQ-034 LEN=00 -> ERR one cycle after the transfer, no mem_we, in_ready=0; a later start returns to LEN with error cleared.
REQ-035 Gaps in in_valid between payload bytes and a start pulse during DATA -> identical writes to REQ-031, and start has no effect.
REQ-036 rst_n low after the second payload byte -> all outputs take reset values at once, no third write, and IDLE persists after release.

Source files
------------

// File: rtl/program_loader.sv
// Frame-based instruction-memory loader: receives LEN, payload and checksum bytes
// over a valid/ready stream and writes each payload byte to consecutive addresses.
module program_loader #(
  parameter logic [7:0] BASE_ADDR = 8'h00
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       mem_we,
  output logic [7:0] mem_addr,
  output logic [7:0] mem_wdata,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic [8:0] count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_DATA,
    S_CSUM,
    S_DONE,
    S_ERR
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic       xfer;
  logic       launch;
  logic [7:0] sum;
  logic [7:0] remaining;
  logic [7:0] ptr;
  logic [7:0] csum_total;

  assign in_ready   = (state == S_LEN) || (state == S_DATA) || (state == S_CSUM);
  assign busy       = in_ready;
  assign xfer       = in_valid && in_ready;
  assign launch     = start && ((state == S_IDLE) || (state == S_DONE) || (state == S_ERR));
  assign csum_total = sum + in_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) state_nxt = S_LEN;
      end
      S_LEN: begin
        if (xfer) state_nxt = (in_data == 8'h00) ? S_ERR : S_DATA;
      end
      S_DATA: begin
        if (xfer && (remaining == 8'd1)) state_nxt = S_CSUM;
      end
      S_CSUM: begin
        if (xfer) state_nxt = (csum_total == 8'h00) ? S_DONE : S_ERR;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // The write is registered: the accepted byte appears on the memory port
  // one cycle later, and count/ptr advance on that same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_we    <= 1'b0;
      mem_addr  <= BASE_ADDR;
      mem_wdata <= '0;
      done      <= 1'b0;
      error     <= 1'b0;
      count     <= '0;
      sum       <= '0;
      remaining <= '0;
      ptr       <= BASE_ADDR;
    end else begin
      mem_we <= 1'b0;
      if (launch) begin
        done      <= 1'b0;
        error     <= 1'b0;
        count     <= '0;
        sum       <= '0;
        remaining <= '0;
        ptr       <= BASE_ADDR;
      end
      if (xfer) begin
        case (state)
          S_LEN: begin
            remaining <= in_data;
            if (in_data == 8'h00) error <= 1'b1;
          end
          S_DATA: begin
            sum       <= csum_total;
            remaining <= remaining - 8'd1;
            mem_we    <= 1'b1;
            mem_addr  <= ptr;
            mem_wdata <= in_data;
            ptr       <= ptr + 8'd1;
            count     <= count + 9'd1;
          end
          S_CSUM: begin
            if (csum_total == 8'h00) done <= 1'b1;
            else                     error <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule
